// File: rtl/io_bus_bridge_if.sv
// CPU-side I/O bus bundle between the 8088 bus interface and the I/O bridge.
// Valid/ready contract: a cycle is requested while cpu_iom=1 and exactly one
// of cpu_rd_n/cpu_wr_n is low; the bridge completes it when it returns
// cpu_ready=1, and the CPU must then release both strobes for at least one
// clock before it starts the next cycle.
interface io_bus_bridge_if;
    logic        cpu_iom;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic [19:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_ready;
    logic [7:0]  io_din;
    logic        io_hit;
    logic        bus_err;

    modport master (
        output cpu_iom, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_dout,
        input  cpu_ready, io_din, io_hit, bus_err
    );

    modport slave (
        input  cpu_iom, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_dout,
        output cpu_ready, io_din, io_hit, bus_err
    );
endinterface

// File: rtl/io_bus_bridge.sv
// I/O-space front end: decodes CPU I/O cycles into N_DEV device windows,
// drives registered chip selects/strobes, inserts per-device wait states,
// latches read data and flags unmapped or illegal I/O cycles.
module io_bus_bridge #(
    parameter int N_DEV = 4,
    parameter int WS_W  = 4,
    parameter logic [N_DEV*16-1:0]   DEV_BASE = {16'h0080, 16'h0060, 16'h0040, 16'h0020},
    parameter logic [N_DEV*16-1:0]   DEV_MASK = {16'hFFF8, 16'hFFFC, 16'hFFFC, 16'hFFFE},
    parameter logic [N_DEV*WS_W-1:0] DEV_WS   = {4'd0, 4'd3, 4'd1, 4'd0}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_bus_bridge_if.slave       bus,
    output logic [N_DEV-1:0]     dev_cs_n,
    output logic                 dev_rd_n,
    output logic                 dev_wr_n,
    output logic [1:0]           dev_a,
    output logic [7:0]           dev_wdata,
    input  logic [N_DEV*8-1:0]   dev_rdata,
    output logic [1:0]           state_dbg
);
    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WS_W-1:0]    cnt_q;
    logic [IDX_W-1:0]   sel_q;
    logic               err_pend_q;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [N_DEV-1:0]   hit_cs_n;
    logic               req, illegal, strobes_high, start, reject;
    logic               unused_addr_hi;

    // Only the low 16 address bits select an I/O port.
    assign unused_addr_hi = ^bus.cpu_addr[19:16];

    assign strobes_high = bus.cpu_rd_n & bus.cpu_wr_n;
    assign req          = bus.cpu_iom & (bus.cpu_rd_n ^ bus.cpu_wr_n);
    assign illegal      = bus.cpu_iom & ~bus.cpu_rd_n & ~bus.cpu_wr_n;

    // A pending error blocks new requests until the strobes release, so a
    // single strobe assertion can never yield both an error and an access.
    assign start  = (state_q == S_IDLE) && !err_pend_q && req && hit;
    assign reject = (state_q == S_IDLE) && !err_pend_q && (illegal || (req && !hit));

    // Window decode; scanning downward lets the lowest matching index win.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_cs_n = '1;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if ((bus.cpu_addr[15:0] & DEV_MASK[i*16 +: 16]) ==
                (DEV_BASE[i*16 +: 16] & DEV_MASK[i*16 +: 16])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_DEV; i++) begin
            hit_cs_n[i] = (IDX_W'(i) != hit_idx);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: an access ends on the last wait state, or early when
    // the CPU drops both strobes (abort).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ACCESS;
            S_ACCESS: begin
                if (strobes_high)     state_d = S_IDLE;
                else if (cnt_q == '0) state_d = S_HOLD;
            end
            S_HOLD:   if (strobes_high) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // READY drops in the request cycle itself so the CPU inserts waits before
    // the access register stage sees it; reset forces it high immediately.
    assign bus.cpu_ready = ~rst_n | ~(start | (state_q == S_ACCESS));
    assign bus.io_hit    = (state_q != S_IDLE);
    assign state_dbg     = state_q;

    // Device strobes, wait counter, read-data latch and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_cs_n   <= '1;
            dev_rd_n   <= 1'b1;
            dev_wr_n   <= 1'b1;
            dev_a      <= 2'b00;
            dev_wdata  <= 8'h00;
            cnt_q      <= '0;
            sel_q      <= '0;
            bus.io_din <= 8'hFF;
            bus.bus_err <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            bus.bus_err <= reject;
            if (strobes_high)  err_pend_q <= 1'b0;
            else if (reject)   err_pend_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dev_cs_n  <= hit_cs_n;
                        dev_rd_n  <= bus.cpu_rd_n;
                        dev_wr_n  <= bus.cpu_wr_n;
                        dev_a     <= bus.cpu_addr[1:0];
                        dev_wdata <= bus.cpu_dout;
                        cnt_q     <= DEV_WS[hit_idx*WS_W +: WS_W];
                        sel_q     <= hit_idx;
                    end else if (reject) begin
                        bus.io_din <= 8'hFF;
                    end
                end
                S_ACCESS: begin
                    if (strobes_high) begin
                        dev_cs_n <= '1;
                        dev_rd_n <= 1'b1;
                        dev_wr_n <= 1'b1;
                    end else if (cnt_q == '0) begin
                        if (!dev_rd_n) bus.io_din <= dev_rdata[sel_q*8 +: 8];
                        dev_cs_n <= '1;
                        dev_rd_n <= 1'b1;
                        dev_wr_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/io_bus_bridge.md
# io_bus_bridge

Parametrised I/O-space front end for the 8088 system bus. It decodes CPU I/O cycles into up to `N_DEV` peripheral windows (PIC, PIT, future UART/GPIO) and drives per-device chip selects and registered read/write strobes. It inserts a per-device number of wait states by deasserting `cpu_ready`, and latches read data for `cpu_din`. It replaces the fixed single-cycle, READY-tied-high I/O decode with configurable windows, wait states, abort handling and unmapped-access reporting.

## Interface
Parameters:
- `N_DEV`, 4: number of device windows (1..8).
- `WS_W`, 4: width of a wait-state count.
- `DEV_BASE`, {16'h0080,16'h0060,16'h0040,16'h0020}: packed 16-bit base port per device; device 0 is in the LSBs.
- `DEV_MASK`, {16'hFFF8,16'hFFFC,16'hFFFC,16'hFFFE}: packed 16-bit compare masks.
- `DEV_WS`, {4'd0,4'd3,4'd1,4'd0}: packed wait states per device.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_iom` in 1: 1 = I/O cycle.
- `cpu_rd_n`, `cpu_wr_n` in 1: CPU strobes, active-low.
- `cpu_addr` in 20: CPU address. Bits [15:0] are used for decode.
- `cpu_dout` in 8: CPU write data.
- `cpu_ready` out 1: READY to the CPU.
- `io_din` out 8: latched read data toward the `cpu_din` mux.
- `io_hit` out 1: high while a mapped access is in progress (ACCESS or HOLD).
- `bus_err` out 1: one-cycle pulse on an unmapped or illegal I/O cycle.
- `dev_cs_n` out N_DEV: per-device chip selects, active-low.
- `dev_rd_n`, `dev_wr_n` out 1: registered device strobes.
- `dev_a` out 2: `cpu_addr[1:0]`, registered.
- `dev_wdata` out 8: registered write data.
- `dev_rdata` in N_DEV*8: packed device read data.

## Operation
- **Request detection:** a request is `cpu_iom`=1 and exactly one of `cpu_rd_n`/`cpu_wr_n` low, sampled in IDLE.
- **Decode:** device i hits when `(cpu_addr[15:0] & MASK_i) == (BASE_i & MASK_i)`. Overlapping windows resolve to the lowest index.
- **FSM states:** IDLE, ACCESS, HOLD.
  - IDLE → ACCESS on a request that hits.
    - Register `dev_cs_n[i]`=0, the matching strobe, `dev_a`, `dev_wdata`=`cpu_dout`, and `cnt`=WS_i.
  - ACCESS: if `cnt`≠0, decrement `cnt`.
  - ACCESS → HOLD when `cnt`==0 at a clock edge.
    - On a read, latch `dev_rdata[i]` into `io_din`.
    - Deassert all `dev_cs_n` and strobes.
  - ACCESS → IDLE (abort) if both CPU strobes go high. Strobes and chip select drop at that edge and `io_din` is not updated.
  - HOLD → IDLE when both `cpu_rd_n` and `cpu_wr_n` are high.
- **Unmapped request** (no hit): no chip select, stay in IDLE, `cpu_ready` stays 1, `io_din` is set to 8'hFF, `bus_err` pulses for 1 cycle.
- **Illegal request** (`cpu_iom`=1 with both strobes low): treated as unmapped (`bus_err` pulse, no access).
- Only one `bus_err` pulse is issued per CPU strobe assertion. A pending flag clears when the strobes release.
- Memory cycles (`cpu_iom`=0) are ignored entirely.

## Timing
- **Reset values:** `cpu_ready`=1, `io_din`=8'hFF, `io_hit`=0, `bus_err`=0, `dev_cs_n`=all 1, `dev_rd_n`=`dev_wr_n`=1, `dev_a`=0, `dev_wdata`=0, state IDLE.
- **`cpu_ready`** = 0 combinationally when (IDLE and a hitting request is present) or (state ACCESS). Otherwise it is 1.
- **Strobe/ready window:** for wait count W, device strobes are low for W+1 cycles. `cpu_ready` is low from the request cycle through the last ACCESS cycle, i.e. W+2 cycles.
- **Read data:** `io_din` is valid from the first HOLD cycle and holds until the next read or unmapped cycle.
- **Async reset mid-access:** reset forces all outputs to their reset values immediately. No partial strobe survives.
- **Back-to-back:** a new request is accepted only from IDLE, so the CPU strobes must release for at least 1 cycle between accesses.

## Test plan
- **Read, W=0:** read from port 8'h20 (device 0, `dev_rdata[7:0]`=8'h5A) → `dev_cs_n[0]` and `dev_rd_n` low for 1 cycle; `cpu_ready` low for 2 cycles; `io_din`=8'h5A in HOLD.
- **Write, W=3:** write of 8'hC3 to port 16'h0062 (device 2) → `dev_cs_n`=4'b1011, `dev_wr_n` low for 4 cycles, `dev_wdata`=8'hC3, `dev_a`=2'b10; `cpu_ready` low for 5 cycles.
- **Unmapped read:** read from port 16'h0300 → no chip select, `cpu_ready` stays 1, `bus_err` is a single 1-cycle pulse, `io_din`=8'hFF.
- **Abort:** read to device 2 (W=3) with `cpu_rd_n` released after 2 ACCESS cycles → strobes drop at the next edge, state returns to IDLE, `io_din` is unchanged.
- **Reset mid-op:** `rst_n` low during ACCESS → `dev_cs_n`=4'hF, `cpu_ready`=1 and `io_hit`=0 without waiting for a clock edge.
- **Memory cycle:** with `cpu_iom`=0 and `cpu_addr`=16'h0020 → no response at all.
